// File: rtl/main_memory_ctrl_if.sv
// Cache <-> main memory block-transfer bus.
// master: cache side (issues requests, supplies write beats).
// slave : memory controller side (sequences the burst, returns refill beats).
interface main_memory_ctrl_if;
   logic        req;
   logic        write;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic        busy;
   logic        beat_valid;
   logic [1:0]  beat_idx;
   logic [31:0] rdata;
   logic        done;

   modport master (
      output req, write, addr, wdata,
      input  busy, beat_valid, beat_idx, rdata, done
   );

   modport slave (
      input  req, write, addr, wdata,
      output busy, beat_valid, beat_idx, rdata, done
   );
endinterface

// File: rtl/main_memory_ctrl.sv
// Main memory controller: 256 x 32-bit store, 4-beat block bursts for
// cache refill (read) and write-back (write).
// Optional wait states before the first beat are enabled by defining
// MEM_WAIT_STATES_EN; LATENCY (1..15) then sets the number of WAIT cycles.
// Without the macro the WAIT state and its counter are not built.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for req; latches block and direction on accept
// ST_WAIT  | access latency, down-counter from LATENCY-1 to 0
// ST_BURST | four beats, beat_idx 0..3
// ST_DONE  | one-cycle completion pulse, then back to ST_IDLE
module main_memory_ctrl #(
   parameter int unsigned LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   main_memory_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  blk_q, blk_d;
   logic        wr_q, wr_d;
   logic [1:0]  beat_q, beat_d;

   logic [31:0] mem_q [0:255];
   logic        mem_we;
   logic [7:0]  mem_addr;

`ifdef MEM_WAIT_STATES_EN
   localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);
   logic [3:0]  cnt_q, cnt_d;
`else
   localparam int unsigned UNUSED_LATENCY = LATENCY;
`endif

   // Only the block field of the address matters; word offset comes from beat_q.
   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.addr[3:0];

   // Next-state and transaction-context logic.
   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      wr_d    = wr_q;
      beat_d  = beat_q;
`ifdef MEM_WAIT_STATES_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               blk_d  = bus.addr[9:4];
               wr_d   = bus.write;
               beat_d = 2'd0;
`ifdef MEM_WAIT_STATES_EN
               cnt_d   = WAIT_LOAD;
               state_d = ST_WAIT;
`else
               state_d = ST_BURST;
`endif
            end
         end
`ifdef MEM_WAIT_STATES_EN
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_BURST;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         ST_BURST: begin
            // beat_q wraps to 0 after beat 3; it never touches the block field.
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         blk_q   <= 6'd0;
         wr_q    <= 1'b0;
         beat_q  <= 2'd0;
`ifdef MEM_WAIT_STATES_EN
         cnt_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         wr_q    <= wr_d;
         beat_q  <= beat_d;
`ifdef MEM_WAIT_STATES_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Write beats commit at the edge ending the beat; a reset on that edge
   // cancels the beat so an aborted write-back leaves later words untouched.
   always_comb begin
      mem_addr = {blk_q, beat_q};
      mem_we   = rst_n && (state_q == ST_BURST) && wr_q;
   end

   // Storage array, deliberately outside reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_addr] <= bus.wdata;
      end
   end

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.beat_valid = (state_q == ST_BURST);
   assign bus.beat_idx   = beat_q;
   assign bus.done       = (state_q == ST_DONE);
   assign bus.rdata      = ((state_q == ST_BURST) && !wr_q) ? mem_q[mem_addr] : 32'd0;

endmodule
